// File: rtl/counting123_pkg.sv
// Shared types and symbol encoding for the counting 1-2-3 generator and detector.
package counting123_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ONE,
    TWO,
    THREE,
    GAP,
    DONE
  } state_t;

  localparam logic [1:0] SYM_IDLE  = 2'd0;
  localparam logic [1:0] SYM_ONE   = 2'd1;
  localparam logic [1:0] SYM_TWO   = 2'd2;
  localparam logic [1:0] SYM_THREE = 2'd3;

  // First phase after `s` whose run length is nonzero; DONE when none remain.
  function automatic state_t next_phase(input state_t s, input logic nz1,
                                        input logic nz2, input logic nz3);
    state_t r;
    r = DONE;
    case (s)
      IDLE:    r = nz1 ? ONE : (nz2 ? TWO : (nz3 ? THREE : DONE));
      ONE:     r = nz2 ? TWO : (nz3 ? THREE : DONE);
      TWO:     r = nz3 ? THREE : DONE;
      default: r = DONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/counting123_gen_if.sv
// Request/stream bundle between a frame requester and the counting 1-2-3 generator.
interface counting123_gen_if #(parameter int CNT_W = 4);
  logic             start;
  logic [CNT_W-1:0] n1;
  logic [CNT_W-1:0] n2;
  logic [CNT_W-1:0] n3;
  logic [1:0]       num;
  logic             busy;
  logic             done;

  modport master (output start, n1, n2, n3, input num, busy, done);
  modport slave  (input start, n1, n2, n3, output num, busy, done);
endinterface

// File: rtl/counting123_burst.sv
// Loadable run-length down-counter; reloaded on entry to each symbol phase.
module counting123_burst #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             en,
  output logic             last,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Holds at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= len;
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign last = (cnt == CNT_W'(1));
  assign zero = (cnt == '0);

endmodule

// File: rtl/counting123_gen.sv
// Framed 1/2/3 symbol stream generator. Define COUNTING123_GAP_EN to insert one
// idle GAP cycle between consecutive emitted phases.
module counting123_gen
  import counting123_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  counting123_gen_if.slave bus
);

  state_t           state, state_nxt, target;
  logic [CNT_W-1:0] c1, c2, c3;
  logic [CNT_W-1:0] s1, s2, s3;
  logic [CNT_W-1:0] load_len;
  logic             load, in_phase, last, zero;
  logic [1:0]       num_nxt;
  logic             busy_nxt, done_nxt;
`ifdef COUNTING123_GAP_EN
  state_t           pend;
`endif

  // In IDLE the counts are being latched this edge, so use the live request.
  assign s1 = (state == IDLE) ? bus.n1 : c1;
  assign s2 = (state == IDLE) ? bus.n2 : c2;
  assign s3 = (state == IDLE) ? bus.n3 : c3;

  assign in_phase = (state == ONE) || (state == TWO) || (state == THREE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      c1       <= '0;
      c2       <= '0;
      c3       <= '0;
      bus.num  <= SYM_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
`ifdef COUNTING123_GAP_EN
      pend     <= IDLE;
`endif
    end else begin
      state    <= state_nxt;
      bus.num  <= num_nxt;
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
      if (state == IDLE && bus.start) begin
        c1 <= bus.n1;
        c2 <= bus.n2;
        c3 <= bus.n3;
      end
`ifdef COUNTING123_GAP_EN
      if (state_nxt == GAP)
        pend <= target;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    target    = DONE;
    case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = next_phase(IDLE, |bus.n1, |bus.n2, |bus.n3);
      end
      ONE, TWO, THREE: begin
        if (last || zero) begin
          target = next_phase(state, |c1, |c2, |c3);
`ifdef COUNTING123_GAP_EN
          state_nxt = (target == DONE) ? DONE : GAP;
`else
          state_nxt = target;
`endif
        end
      end
`ifdef COUNTING123_GAP_EN
      GAP:     state_nxt = pend;
`else
      GAP:     state_nxt = IDLE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    num_nxt  = SYM_IDLE;
    load_len = '0;
    case (state_nxt)
      ONE:   begin num_nxt = SYM_ONE;   load_len = s1; end
      TWO:   begin num_nxt = SYM_TWO;   load_len = s2; end
      THREE: begin num_nxt = SYM_THREE; load_len = s3; end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    load     = (state_nxt == ONE || state_nxt == TWO || state_nxt == THREE)
               && (state_nxt != state);
  end

  counting123_burst #(.CNT_W(CNT_W)) u_burst (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .len   (load_len),
    .en    (in_phase),
    .last  (last),
    .zero  (zero)
  );

endmodule

// File: tb/tb_counting123_gen.sv
// Self-checking bench for counting123_gen against a per-frame symbol-list model.
module tb_counting123_gen;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  counting123_gen_if #(.CNT_W(CNT_W)) bus ();

  counting123_gen #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_num"},  4'(bus.num),  4'd0);
    chk({tag, "_busy"}, 4'(bus.busy), 4'd0);
    chk({tag, "_done"}, 4'(bus.done), 4'd0);
  endtask

  // Expected stream: each nonzero run in order, optional single idle gap between
  // emitted runs, then one idle DONE cycle; busy is high on every entry.
  task automatic build(input int a, input int b, input int c,
                       output int q_num[$], output int q_done[$]);
    int  cnt[3];
    bit  emitted;
    cnt = '{a, b, c};
    emitted = 1'b0;
    q_num.delete();
    q_done.delete();
    for (int p = 0; p < 3; p++) begin
      if (cnt[p] != 0) begin
`ifdef COUNTING123_GAP_EN
        if (emitted) begin q_num.push_back(0); q_done.push_back(0); end
`endif
        emitted = 1'b1;
        for (int k = 0; k < cnt[p]; k++) begin
          q_num.push_back(p + 1);
          q_done.push_back(0);
        end
      end
    end
    q_num.push_back(0);
    q_done.push_back(1);
  endtask

  task automatic do_frame(input int a, input int b, input int c, input bit noisy);
    int q_num[$];
    int q_done[$];
    build(a, b, c, q_num, q_done);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n1 = CNT_W'(a);
    bus.n2 = CNT_W'(b);
    bus.n3 = CNT_W'(c);
    for (int i = 0; i < q_num.size(); i++) begin
      @(posedge clk); #1;
      chk("frame_num",  4'(bus.num),  4'(q_num[i]));
      chk("frame_busy", 4'(bus.busy), 4'd1);
      chk("frame_done", 4'(bus.done), 4'(q_done[i]));
      @(negedge clk);
      if (noisy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.n1 = CNT_W'($urandom);
        bus.n2 = CNT_W'($urandom);
        bus.n3 = CNT_W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk_idle("after_done");
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk_idle("idle");
  endtask

  initial begin
    int a, b, c;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.n1 = 4'd3; bus.n2 = 4'd3; bus.n3 = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    idle_cycle();

    do_frame(2, 1, 3, 1'b0);
    do_frame(0, 2, 0, 1'b0);
    do_frame(0, 0, 0, 1'b0);
    do_frame(15, 15, 15, 1'b0);
    do_frame(1, 1, 1, 1'b0);
    do_frame(3, 0, 2, 1'b1);
    do_frame(0, 4, 5, 1'b1);
    idle_cycle();

    // Reset asserted while the TWO run is being emitted abandons the frame.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n1 = 4'd2; bus.n2 = 4'd3; bus.n3 = 4'd1;
    @(posedge clk); #1;
    chk("rst_mid_num1", 4'(bus.num), 4'd1);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_num1b", 4'(bus.num), 4'd1);
`ifdef COUNTING123_GAP_EN
    @(posedge clk); #1;
    chk("rst_mid_gap", 4'(bus.num), 4'd0);
`endif
    @(posedge clk); #1;
    chk("rst_mid_num2", 4'(bus.num), 4'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_idle("rst_abandon");
    end

    // Start coinciding with reset is dropped.
    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk_idle("rst_vs_start");
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk_idle("rst_vs_start2");

    for (int t = 0; t < 20; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      do_frame(a, b, c, 1'($urandom_range(0, 1)));
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/counting123_gen.md
# counting123_gen

Stimulus generator for the `counting` 1-2-3 sequence detector. It emits a framed 2-bit symbol stream on `num`: a run of `1`s, then a run of `2`s, then a run of `3`s, with run lengths taken from a start request. It sits upstream of `counting`. Testbenches and higher-level blocks use it to produce legal and edge-case streams, such as zero-length runs and back-to-back frames, without hand-coded stimulus.

## Interface
Parameters:
- `CNT_W`, 4, width of each run-length count; each run can be 0..2^CNT_W-1 symbols.

Ports:
- `clk`, input, 1, single clock; all logic on rising edge.
- `rst_n`, input, 1, reset, synchronous and active-low.
- `start`, input, 1, frame request; sampled only in IDLE.
- `n1`, input, CNT_W, number of `1` symbols in the frame.
- `n2`, input, CNT_W, number of `2` symbols in the frame.
- `n3`, input, CNT_W, number of `3` symbols in the frame.
- `num`, output, 2, symbol stream for the detector; `0` means idle.
- `busy`, output, 1, high from the cycle after `start` is accepted through the cycle that `done` pulses.
- `done`, output, 1, one-cycle pulse marking the end of the frame.

## Operation
- States:
  - IDLE, ONE, TWO, THREE, DONE.
  - With `COUNTING123_GAP_EN`: an additional GAP state.
- IDLE:
  - `num=0`, `busy=0`.
  - `start=1` latches `n1`/`n2`/`n3` into internal registers.
  - Next state is the first phase with a nonzero count; if all three counts are zero, next state is DONE.
- ONE / TWO / THREE:
  - `num` = 1 / 2 / 3 respectively.
  - The phase lasts exactly its latched count in cycles; a down-counter is loaded on entry.
  - When the counter hits 1, advance to the next phase with a nonzero count, else to DONE.
  - Phases with a zero count are skipped entirely and emit no symbols.
- DONE:
  - `num=0`, `done=1`, `busy=1` for one cycle.
  - Returns to IDLE unconditionally.
- Input handling:
  - `start` in any state other than IDLE is ignored; no queuing.
  - `n1`/`n2`/`n3` changing mid-frame has no effect, because the counts were latched at acceptance.
- Arithmetic:
  - Counters are CNT_W bits, unsigned, decrement only, and never wrap.
  - A count of 2^CNT_W-1 emits exactly that many symbols.

## Timing
- Reset values: `num=0`, `busy=0`, `done=0`, state IDLE, latched counts 0.
- Registered outputs: all outputs are registered and update on the rising edge.
- Start latency: `start` high at edge k gives the first symbol on `num` after edge k+1 (1-cycle latency).
- Frame length: frame length = n1+n2+n3 symbol cycles, plus 1 DONE cycle, plus gaps if enabled.
- Back-to-back frames: IDLE is re-entered after DONE, so the earliest next `start` is accepted one cycle after `done`. There is always at least one `num=0` cycle between frames (the DONE cycle).
- All-zero request: `done` pulses in the cycle after acceptance; no symbols are emitted.
- Reset mid-frame:
  - Takes effect at the next edge.
  - Outputs return to reset values.
  - No `done` pulse; the frame is abandoned.
- Simultaneous `start` and `rst_n=0`: reset wins.

## Configuration
- `COUNTING123_GAP_EN` defined:
  - Between two consecutive emitted (nonzero) phases, insert exactly one GAP cycle with `num=0`.
  - No gap is inserted before the first phase or before DONE.
  - Frame length is increased by (number of nonzero phases − 1).
  - This stresses the detector's reaction to idle symbols inside a run.
- `COUNTING123_GAP_EN` not defined:
  - There is no GAP state, and phases are contiguous.

## Structure
- Package `counting123_pkg`:
  - State enum (IDLE, ONE, TWO, THREE, GAP, DONE).
  - Symbol constants `SYM_IDLE=2'd0`, `SYM_ONE=2'd1`, `SYM_TWO=2'd2`, `SYM_THREE=2'd3`.
  - Shared with the detector.
- Sub-module `counting123_burst`:
  - Loadable CNT_W down-counter.
  - Inputs: `load`, `len`, `en`.
  - Outputs: `last`, `zero`.
  - Instantiated once and reloaded per phase.
- Top level: FSM and output registers.

## Test plan
- Reset, then `start` with n1=2, n2=1, n3=3 → `num` = 1,1,2,3,3,3,0; `done` on the 7th cycle after acceptance; `busy` high for 7 cycles.
- n1=0, n2=2, n3=0 → `num` = 2,2; then `done`; no `1` or `3` symbols.
- n1=n2=n3=0 → `done` one cycle after acceptance; `num` stays 0 throughout.
- n1=15, n2=15, n3=15 (CNT_W=4) → exactly 15 symbols per phase, 45 total; no wrap.
- `start` re-asserted mid-frame, and `n1` changed mid-frame → frame unchanged; the second frame starts only via `start` one cycle after `done`.
- `rst_n=0` during TWO → next cycle `num=0`, `busy=0`, no `done`; with `COUNTING123_GAP_EN`, n1=1, n2=1, n3=1 → `num` = 1,0,2,0,3, then `done`.
